fc_layer_controller: RTL and testbench
======================================

// Module: fc_layer_controller
// PURPOSE
//  Sequences one fully-connected layer of the LeNet-5 pipeline (default 400->120).
//  Reads activations and weights from external 1-cycle-latency memories and accumulates
//  one neuron at a time in an internal MAC. Adds the bias, scales, saturates, applies
//  optional ReLU, and writes each neuron result to the output buffer.
//  Sits between the flatten/pool buffer and the next FC stage; start/done handshake to the top FSM.
// PARAMETERS
//  DATA_WIDTH   12   signed activation/weight/bias width (two's complement)
//  INPUT_SIZE   400  activations per neuron
//  OUTPUT_SIZE  120  neurons in the layer
//  FRAC_BITS    6    fractional bits of the fixed-point format (same for all operands)
//  ACC_WIDTH    32   accumulator width
//  RELU_EN      1    1: clamp negative results to 0
// PORTS
//  clk       in   1                                 rising-edge clock
//  rst_n     in   1                                 asynchronous active-low reset
//  start     in   1                                 pulse; sampled only in IDLE
//  busy      out  1                                 high from first MAC cycle until done
//  done      out  1                                 one-cycle pulse, layer complete
//  in_addr   out  $clog2(INPUT_SIZE)                activation read address
//  in_data   in   DATA_WIDTH                        activation, valid 1 cycle after in_addr
//  w_addr    out  $clog2(INPUT_SIZE*OUTPUT_SIZE)    weight address = neuron*INPUT_SIZE+k
//  w_data    in   DATA_WIDTH                        weight, valid 1 cycle after w_addr
//  rd_en     out  1                                 read strobe for both memories
//  b_addr    out  $clog2(OUTPUT_SIZE)               bias address = current neuron
//  b_data    in   DATA_WIDTH                        bias, stable 1 cycle after b_addr
//  out_we    out  1                                 output write strobe
//  out_addr  out  $clog2(OUTPUT_SIZE)               output address = neuron index
//  out_data  out  DATA_WIDTH                        neuron result
// BEHAVIOUR
//  Reset: state IDLE; every output, counter and accumulator is 0. Reset mid-layer aborts
//   immediately. No further out_we or done occurs until a new start.
//  States: IDLE -> MAC -> DRAIN -> WRITE -> (MAC if neuron<OUTPUT_SIZE-1 else DONE) -> IDLE.
//  IDLE: start=1 -> MAC next cycle with k=0, neuron=0, w_addr=0, acc=0.
//  MAC (INPUT_SIZE cycles): rd_en=1, in_addr=k, w_addr increments by 1 each cycle
//   (running counter, no multiplier). k wraps to 0 after INPUT_SIZE-1.
//  Product pipeline: a valid flag is delayed 1 cycle from rd_en. When it is set,
//   acc += sext(in_data)*sext(w_data) (2*DATA_WIDTH product). Overflow wraps mod 2^ACC_WIDTH.
//  DRAIN (1 cycle): rd_en=0; the last product is accumulated.
//  WRITE (1 cycle): out_we=1, out_addr=neuron. Then acc clears, neuron increments, and
//   b_addr advances.
//   r = (acc + (sext(b_data) <<< FRAC_BITS)) >>> FRAC_BITS (arithmetic shift).
//   Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
//   If RELU_EN and r<0 then r=0. out_data=r.
//  DONE: done=1 for exactly one cycle, busy=0, then IDLE. out_data holds its last value.
//  Per neuron: INPUT_SIZE+2 cycles. start sampled at edge 0 -> done high in cycle
//   OUTPUT_SIZE*(INPUT_SIZE+2)+1.
//  start outside IDLE (including the DONE cycle) is ignored; no queuing.
//  b_addr is held for the whole neuron, so b_data is sampled safely in WRITE.
//  out_we only in WRITE; in_addr/w_addr/b_addr read 0 in IDLE.
// TESTING
//  T1 IN=4,OUT=3,FRAC=0; in=1,2,3,4, w=1, b=0 -> out_data=10 at out_addr 0,1,2; done at cycle 19.
//  T2 IN=4,FRAC=0, in=1..4, w=-1, b=2 -> RELU_EN=1: out 0; RELU_EN=0: out -8 (12'hFF8).
//  T3 IN=4,FRAC=0, in=w=2047 -> saturates to 2047; in=2047, w=-2048 -> -2048 (RELU_EN=0).
//  T4 defaults: rd_en stays high 400 cycles per neuron; in_addr runs 0..399 per neuron;
//     last w_addr=47999; 120 out_we pulses; done at cycle 48241.
//  T5 start re-pulsed while busy and in the DONE cycle -> ignored; exactly 1 done pulse per start.
//  T6 rst_n low during neuron 1 MAC -> all outputs 0 asynchronously; then start -> T1 results.

Source files
------------

// File: rtl/fc_layer_controller_if.sv
// Handshake and memory bus of one fully-connected layer controller.
// The master side (sequencer plus activation/weight/bias/output memories)
// drives start and the read data. The slave side (the controller) drives
// the status, the read addresses and the output write port.
interface fc_layer_controller_if #(
    parameter int DATA_WIDTH  = 12,
    parameter int INPUT_SIZE  = 400,
    parameter int OUTPUT_SIZE = 120
);
    localparam int IN_AW  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int W_AW   = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1;
    localparam int OUT_AW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    logic                         start;
    logic                         busy;
    logic                         done;
    logic [IN_AW-1:0]             in_addr;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic [W_AW-1:0]              w_addr;
    logic signed [DATA_WIDTH-1:0] w_data;
    logic                         rd_en;
    logic [OUT_AW-1:0]            b_addr;
    logic signed [DATA_WIDTH-1:0] b_data;
    logic                         out_we;
    logic [OUT_AW-1:0]            out_addr;
    logic signed [DATA_WIDTH-1:0] out_data;

    modport master (
        output start, in_data, w_data, b_data,
        input  busy, done, in_addr, w_addr, rd_en, b_addr, out_we, out_addr, out_data
    );

    modport slave (
        input  start, in_data, w_data, b_data,
        output busy, done, in_addr, w_addr, rd_en, b_addr, out_we, out_addr, out_data
    );
endinterface

// File: rtl/fc_layer_controller.sv
// Fully-connected layer sequencer: streams INPUT_SIZE activation/weight pairs
// per neuron from 1-cycle-latency memories into a MAC, then adds the bias,
// rescales, saturates, optionally applies ReLU and writes the neuron result.
// Every bus output comes straight from a flop; the control flops are loaded
// from the next-state decode so they line up with the state they describe.
module fc_layer_controller #(
    parameter int DATA_WIDTH  = 12,
    parameter int INPUT_SIZE  = 400,
    parameter int OUTPUT_SIZE = 120,
    parameter int FRAC_BITS   = 6,
    parameter int ACC_WIDTH   = 32,
    parameter int RELU_EN     = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    fc_layer_controller_if.slave bus
);
    localparam int IN_AW      = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int W_AW       = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1;
    localparam int OUT_AW     = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(INPUT_SIZE - 1);
    localparam logic [OUT_AW-1:0] N_LAST = OUT_AW'(OUTPUT_SIZE - 1);

    // Saturation bounds expressed at accumulator width so they compare directly.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                       state_r;
    state_t                       next_state_s;
    logic [IN_AW-1:0]             in_addr_r;
    logic [W_AW-1:0]              w_addr_r;
    logic [OUT_AW-1:0]            neuron_r;
    logic [OUT_AW-1:0]            out_addr_r;
    logic                         rd_en_r;
    logic                         valid_r;
    logic                         busy_r;
    logic                         done_r;
    logic                         out_we_r;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic signed [ACC_WIDTH-1:0]  acc_in_s;
    logic signed [PROD_WIDTH-1:0] prod_s;
    logic signed [DATA_WIDTH-1:0] out_data_r;

    // Bias add in the accumulator's fixed-point scale, arithmetic rescale,
    // then ReLU or saturation to the data range.
    function automatic logic signed [DATA_WIDTH-1:0] scale_saturate(
        input logic signed [ACC_WIDTH-1:0]  acc,
        input logic signed [DATA_WIDTH-1:0] bias
    );
        logic signed [ACC_WIDTH-1:0]  bias_ext;
        logic signed [ACC_WIDTH-1:0]  sum;
        logic signed [ACC_WIDTH-1:0]  r;
        logic signed [DATA_WIDTH-1:0] res;
        bias_ext = {{(ACC_WIDTH - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
        sum      = acc + (bias_ext <<< FRAC_BITS);
        r        = sum >>> FRAC_BITS;
        if ((RELU_EN != 0) && r[ACC_WIDTH-1]) begin
            res = {DATA_WIDTH{1'b0}};
        end else if (r > SAT_MAX) begin
            res = SAT_MAX[DATA_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            res = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            res = r[DATA_WIDTH-1:0];
        end
        return res;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) next_state_s = ST_MAC;
                else           next_state_s = ST_IDLE;
            end
            ST_MAC: begin
                if (in_addr_r == K_LAST) next_state_s = ST_DRAIN;
                else                     next_state_s = ST_MAC;
            end
            ST_DRAIN: next_state_s = ST_WRITE;
            ST_WRITE: begin
                if (neuron_r == N_LAST) next_state_s = ST_DONE;
                else                    next_state_s = ST_MAC;
            end
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Signed product of the returned operands and the accumulator update it
    // contributes once the read issued a cycle earlier has landed.
    always_comb begin
        prod_s = PROD_WIDTH'(bus.in_data) * PROD_WIDTH'(bus.w_data);
        if (valid_r) begin
            acc_in_s = acc_r + {{(ACC_WIDTH - PROD_WIDTH){prod_s[PROD_WIDTH-1]}}, prod_s};
        end else begin
            acc_in_s = acc_r;
        end
    end

    // Address counters, accumulator, read-valid pipeline and registered outputs.
    // w_addr holds the last weight address through DRAIN/WRITE and steps into
    // the next neuron's first address on leaving WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_addr_r  <= '0;
            w_addr_r   <= '0;
            neuron_r   <= '0;
            out_addr_r <= '0;
            rd_en_r    <= 1'b0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            out_we_r   <= 1'b0;
            acc_r      <= '0;
            out_data_r <= '0;
        end else begin
            rd_en_r  <= (next_state_s == ST_MAC);
            busy_r   <= (next_state_s == ST_MAC) || (next_state_s == ST_DRAIN) || (next_state_s == ST_WRITE);
            done_r   <= (next_state_s == ST_DONE);
            out_we_r <= (next_state_s == ST_WRITE);
            valid_r  <= rd_en_r;
            case (state_r)
                ST_MAC: begin
                    acc_r <= acc_in_s;
                    if (in_addr_r == K_LAST) begin
                        in_addr_r <= '0;
                    end else begin
                        in_addr_r <= in_addr_r + IN_AW'(1);
                        w_addr_r  <= w_addr_r + W_AW'(1);
                    end
                end
                ST_DRAIN: begin
                    acc_r      <= acc_in_s;
                    out_data_r <= scale_saturate(acc_in_s, bus.b_data);
                    out_addr_r <= neuron_r;
                end
                ST_WRITE: begin
                    acc_r <= '0;
                    if (neuron_r == N_LAST) begin
                        neuron_r <= '0;
                        w_addr_r <= '0;
                    end else begin
                        neuron_r <= neuron_r + OUT_AW'(1);
                        w_addr_r <= w_addr_r + W_AW'(1);
                    end
                end
                default: begin
                    in_addr_r <= '0;
                    w_addr_r  <= '0;
                    neuron_r  <= '0;
                    acc_r     <= '0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.rd_en    = rd_en_r;
    assign bus.in_addr  = in_addr_r;
    assign bus.w_addr   = w_addr_r;
    assign bus.b_addr   = neuron_r;
    assign bus.out_we   = out_we_r;
    assign bus.out_addr = out_addr_r;
    assign bus.out_data = out_data_r;
endmodule

// File: tb/tb_fc_layer_controller.sv
// Bench for fc_layer_controller: three instances (small ReLU, small with
// fractional scaling and no ReLU, full-size default) fed from behavioural
// memories; each written neuron is compared against a dot-product model.
module tb_fc_layer_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    fc_layer_controller_if #(.DATA_WIDTH(12), .INPUT_SIZE(4),   .OUTPUT_SIZE(3))   ifa ();
    fc_layer_controller_if #(.DATA_WIDTH(12), .INPUT_SIZE(5),   .OUTPUT_SIZE(4))   ifb ();
    fc_layer_controller_if #(.DATA_WIDTH(12), .INPUT_SIZE(400), .OUTPUT_SIZE(120)) ifd ();

    fc_layer_controller #(.DATA_WIDTH(12), .INPUT_SIZE(4), .OUTPUT_SIZE(3), .FRAC_BITS(0),
                          .ACC_WIDTH(32), .RELU_EN(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    fc_layer_controller #(.DATA_WIDTH(12), .INPUT_SIZE(5), .OUTPUT_SIZE(4), .FRAC_BITS(3),
                          .ACC_WIDTH(32), .RELU_EN(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    fc_layer_controller #(.DATA_WIDTH(12), .INPUT_SIZE(400), .OUTPUT_SIZE(120), .FRAC_BITS(6),
                          .ACC_WIDTH(32), .RELU_EN(1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

    logic signed [11:0] act_a [4];
    logic signed [11:0] wt_a  [12];
    logic signed [11:0] bias_a[3];
    logic signed [11:0] act_b [5];
    logic signed [11:0] wt_b  [20];
    logic signed [11:0] bias_b[4];
    logic signed [11:0] act_d [400];
    logic signed [11:0] wt_d  [48000];
    logic signed [11:0] bias_d[120];

    int qa_addr[$], qa_data[$], qb_addr[$], qb_data[$], qd_addr[$], qd_data[$];
    int done_a, done_b, done_d;
    int rd_cnt_d, addr_err_d, max_w_d;

    // Synchronous-read memories: data appears one cycle after the address.
    always @(posedge clk) begin
        if (ifa.rd_en) begin
            ifa.in_data <= act_a[ifa.in_addr];
            ifa.w_data  <= wt_a[ifa.w_addr];
        end
        ifa.b_data <= bias_a[ifa.b_addr];
        if (ifb.rd_en) begin
            ifb.in_data <= act_b[ifb.in_addr];
            ifb.w_data  <= wt_b[ifb.w_addr];
        end
        ifb.b_data <= bias_b[ifb.b_addr];
        if (ifd.rd_en) begin
            ifd.in_data <= act_d[ifd.in_addr];
            ifd.w_data  <= wt_d[ifd.w_addr];
        end
        ifd.b_data <= bias_d[ifd.b_addr];
    end

    // Output-write capture, done counting and full-size read-address tracking.
    always @(negedge clk) begin
        if (ifa.out_we) begin qa_addr.push_back(int'(ifa.out_addr)); qa_data.push_back(int'(ifa.out_data)); end
        if (ifb.out_we) begin qb_addr.push_back(int'(ifb.out_addr)); qb_data.push_back(int'(ifb.out_data)); end
        if (ifd.out_we) begin qd_addr.push_back(int'(ifd.out_addr)); qd_data.push_back(int'(ifd.out_data)); end
        if (ifa.done) done_a <= done_a + 1;
        if (ifb.done) done_b <= done_b + 1;
        if (ifd.done) done_d <= done_d + 1;
        if (ifd.rd_en) begin
            if ((int'(ifd.in_addr) != rd_cnt_d % 400) || (int'(ifd.w_addr) != rd_cnt_d))
                addr_err_d <= addr_err_d + 1;
            if (int'(ifd.w_addr) > max_w_d) max_w_d <= int'(ifd.w_addr);
            rd_cnt_d <= rd_cnt_d + 1;
        end
    end

    task automatic check_value(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference neuron: exact dot product, bias at the same scale, floor rescale, clamp.
    function automatic int ref_neuron(input longint dot, input int bias, input int frac, input int relu);
        longint s;
        longint r;
        s = dot + longint'(bias) * (longint'(1) << frac);
        r = s >>> frac;
        if (relu != 0 && r < 0) r = 0;
        else if (r > 2047)      r = 2047;
        else if (r < -2048)     r = -2048;
        return int'(r);
    endfunction

    function automatic longint term(input int sel, input int i, input int k);
        case (sel)
            0:       return longint'(act_a[k]) * longint'(wt_a[i*4 + k]);
            1:       return longint'(act_b[k]) * longint'(wt_b[i*5 + k]);
            default: return longint'(act_d[k]) * longint'(wt_d[i*400 + k]);
        endcase
    endfunction

    function automatic int bias_of(input int sel, input int i);
        case (sel)
            0:       return int'(bias_a[i]);
            1:       return int'(bias_b[i]);
            default: return int'(bias_d[i]);
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return ifa.done;
            1:       return ifb.done;
            default: return ifd.done;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return ifa.busy;
            1:       return ifb.busy;
            default: return ifd.busy;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       ifa.start = v;
            1:       ifb.start = v;
            default: ifd.start = v;
        endcase
    endtask

    task automatic clear_capture(input int sel);
        case (sel)
            0: begin qa_addr.delete(); qa_data.delete(); done_a = 0; end
            1: begin qb_addr.delete(); qb_data.delete(); done_b = 0; end
            default: begin
                qd_addr.delete(); qd_data.delete(); done_d = 0;
                rd_cnt_d = 0; addr_err_d = 0; max_w_d = -1;
            end
        endcase
    endtask

    // Operand fill: ramp (k+1) or constant activations, constant weights and bias.
    task automatic fill(input int sel, input bit ramp, input int aval, input int wval, input int bval);
        case (sel)
            0: begin
                foreach (act_a[k])  act_a[k]  = ramp ? 12'(k + 1) : 12'(aval);
                foreach (wt_a[k])   wt_a[k]   = 12'(wval);
                foreach (bias_a[k]) bias_a[k] = 12'(bval);
            end
            default: begin
                foreach (act_b[k])  act_b[k]  = ramp ? 12'(k + 1) : 12'(aval);
                foreach (wt_b[k])   wt_b[k]   = 12'(wval);
                foreach (bias_b[k]) bias_b[k] = 12'(bval);
            end
        endcase
    endtask

    function automatic int rnd(input int m);
        return int'($urandom_range(0, 2*m - 1)) - m;
    endfunction

    task automatic fill_random(input int sel, input int arng, input int wrng);
        case (sel)
            0: begin
                foreach (act_a[k])  act_a[k]  = 12'(rnd(arng));
                foreach (wt_a[k])   wt_a[k]   = 12'(rnd(wrng));
                foreach (bias_a[k]) bias_a[k] = 12'(rnd(2048));
            end
            1: begin
                foreach (act_b[k])  act_b[k]  = 12'(rnd(arng));
                foreach (wt_b[k])   wt_b[k]   = 12'(rnd(wrng));
                foreach (bias_b[k]) bias_b[k] = 12'(rnd(2048));
            end
            default: begin
                foreach (act_d[k])  act_d[k]  = 12'(rnd(arng));
                foreach (wt_d[k])   wt_d[k]   = 12'(rnd(wrng));
                foreach (bias_d[k]) bias_d[k] = 12'(rnd(2048));
            end
        endcase
    endtask

    // One layer run: start sampled at edge 0; done_cyc = edges to done + 1.
    task automatic run_layer(input int sel, input int budget, input bit repulse, output int done_cyc);
        done_cyc = -1;
        clear_capture(sel);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1 set_start(sel, 1'b0);
        @(negedge clk);
        check_value($sformatf("busy_after_start_%0d", sel), busy_of(sel), 1);
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_of(sel)) begin
                done_cyc = n + 1;
                check_value($sformatf("busy_in_done_%0d", sel), busy_of(sel), 0);
                if (repulse) set_start(sel, 1'b1);
                break;
            end
            if (repulse) set_start(sel, (n == 7));
        end
        @(posedge clk);
        #1 set_start(sel, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    // Compare captured writes with the model, neuron by neuron.
    task automatic score(input int sel, input string tag);
        int got_a[$];
        int got_d[$];
        int in_n, out_n, frac, relu, expv;
        longint dot;
        case (sel)
            0:       begin in_n = 4;   out_n = 3;   frac = 0; relu = 1; got_a = qa_addr; got_d = qa_data; end
            1:       begin in_n = 5;   out_n = 4;   frac = 3; relu = 0; got_a = qb_addr; got_d = qb_data; end
            default: begin in_n = 400; out_n = 120; frac = 6; relu = 1; got_a = qd_addr; got_d = qd_data; end
        endcase
        check_value({tag, "_out_count"}, got_d.size(), out_n);
        for (int i = 0; i < out_n && i < got_d.size(); i++) begin
            dot = 0;
            for (int k = 0; k < in_n; k++) dot += term(sel, i, k);
            expv = ref_neuron(dot, bias_of(sel, i), frac, relu);
            check_value($sformatf("%s_addr%0d", tag, i), got_a[i], i);
            check_value($sformatf("%s_data%0d", tag, i), got_d[i], expv);
        end
    endtask

    task automatic expect_all(input int sel, input string tag, input int value);
        int got_d[$];
        if (sel == 0) got_d = qa_data;
        else          got_d = qb_data;
        for (int i = 0; i < got_d.size(); i++)
            check_value($sformatf("%s_%0d", tag, i), got_d[i], value);
    endtask

    initial begin
        int dc;
        rst_n = 1'b0;
        ifa.start = 1'b0; ifb.start = 1'b0; ifd.start = 1'b0;
        clear_capture(0); clear_capture(1); clear_capture(2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_busy",     ifa.busy, 0);
        check_value("rst_done",     ifa.done, 0);
        check_value("rst_rd_en",    ifa.rd_en, 0);
        check_value("rst_out_we",   ifa.out_we, 0);
        check_value("rst_in_addr",  ifa.in_addr, 0);
        check_value("rst_w_addr",   ifd.w_addr, 0);
        check_value("rst_b_addr",   ifa.b_addr, 0);
        check_value("rst_out_addr", ifa.out_addr, 0);
        check_value("rst_out_data", ifa.out_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ramp activations, unit weights, zero bias; repeat start while busy and in DONE.
        fill(0, 1'b1, 0, 1, 0);
        run_layer(0, 100, 1'b1, dc);
        check_value("t1_done_cycle", dc, 19);
        check_value("t1_done_count", done_a, 1);
        expect_all(0, "t1_value", 10);
        score(0, "t1");

        // Negative sums: ReLU clamps to 0 on A; B floors -15/8 to -2.
        fill(0, 1'b1, 0, -1, 2);
        run_layer(0, 100, 1'b0, dc);
        expect_all(0, "t2_relu", 0);
        score(0, "t2a");
        fill(1, 1'b1, 0, -1, 0);
        run_layer(1, 100, 1'b0, dc);
        check_value("t2b_done_cycle", dc, 4*(5+2)+1);
        expect_all(1, "t2b_floor", -2);
        score(1, "t2b");

        // Saturation to both rails without ReLU.
        fill(1, 1'b0, 2047, 2047, 0);
        run_layer(1, 100, 1'b0, dc);
        expect_all(1, "t3_pos_sat", 2047);
        fill(1, 1'b0, 2047, -2048, 0);
        run_layer(1, 100, 1'b0, dc);
        expect_all(1, "t3_neg_sat", -2048);

        // Asynchronous reset during neuron 1 accumulation aborts the layer.
        fill(0, 1'b1, 0, 1, 0);
        clear_capture(0);
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("t6_busy",     ifa.busy, 0);
        check_value("t6_rd_en",    ifa.rd_en, 0);
        check_value("t6_in_addr",  ifa.in_addr, 0);
        check_value("t6_w_addr",   ifa.w_addr, 0);
        check_value("t6_b_addr",   ifa.b_addr, 0);
        check_value("t6_out_data", ifa.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check_value("t6_writes_before_abort", qa_data.size(), 1);
        check_value("t6_no_done", done_a, 0);
        run_layer(0, 100, 1'b0, dc);
        check_value("t6_rerun_done_cycle", dc, 19);
        expect_all(0, "t6_rerun_value", 10);

        // Randomized operands on both small instances.
        for (int r = 0; r < 4; r++) begin
            fill_random(0, 40, 40);
            run_layer(0, 100, 1'b0, dc);
            score(0, $sformatf("rand_a%0d", r));
            fill_random(1, 60, 60);
            run_layer(1, 100, 1'b0, dc);
            score(1, $sformatf("rand_b%0d", r));
        end

        // Full-size layer with default parameters.
        fill_random(2, 64, 64);
        run_layer(2, 50000, 1'b1, dc);
        check_value("t4_done_cycle", dc, 48241);
        check_value("t4_done_count", done_d, 1);
        check_value("t4_rd_cycles", rd_cnt_d, 48000);
        check_value("t4_addr_seq_errors", addr_err_d, 0);
        check_value("t4_last_w_addr", max_w_d, 47999);
        check_value("t4_idle_w_addr", ifd.w_addr, 0);
        score(2, "t4");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
